// File: rtl/fsm_ctx_sched.sv
// Round-robin time-shared sequence detector: one shared next-state step, per-channel
// state/count context, registered result tagged with the channel id.
module fsm_ctx_sched #(
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int HOLD_MAX = 18
) (
  input  logic           clk,
  input  logic           init,
  input  logic           en,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] q,
  output logic [NCH-1:0] ack,
  input  logic           clr_ch,
  input  logic [CHW-1:0] clr_id,
  output logic           z_valid,
  output logic           z,
  output logic [CHW-1:0] z_ch,
  output logic [2:0]     z_state,
  output logic [4:0]     z_count
);

  typedef enum logic [2:0] {
    ST_A  = 3'b000,
    ST_C  = 3'b001,
    ST_EH = 3'b010,
    ST_BD = 3'b011,
    ST_FG = 3'b100
  } state_t;

  localparam logic [4:0]     HOLD_C  = 5'(HOLD_MAX);
  localparam logic [CHW-1:0] PTR_RST = CHW'(NCH - 1);

  logic [2:0]     r_st  [NCH];
  logic [4:0]     r_cnt [NCH];
  logic [CHW-1:0] r_ptr;

  logic           r_z_valid;
  logic           r_z;
  logic [CHW-1:0] r_z_ch;
  logic [2:0]     r_z_state;
  logic [4:0]     r_z_count;

  logic [NCH-1:0] w_clr_mask;
  logic [NCH-1:0] w_elig;
  logic           w_gnt_vld;
  logic [CHW-1:0] w_gnt_id;
  logic [2:0]     w_s;
  logic [4:0]     w_c;
  logic           w_x;
  logic [2:0]     w_nst;
  logic [4:0]     w_ncnt;
  logic           w_nz;

  // A channel being cleared is excluded from the grant, so clear beats request.
  always_comb begin
    w_clr_mask = '0;
    if (clr_ch && (int'(clr_id) < NCH)) w_clr_mask[clr_id] = 1'b1;
  end

  assign w_elig = req & ~w_clr_mask & {NCH{en}};

  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(r_ptr) + 1 + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!w_gnt_vld && w_elig[CHW'(idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = CHW'(idx);
      end
    end
  end

  always_comb begin
    ack = '0;
    if (w_gnt_vld) ack[w_gnt_id] = 1'b1;
  end

  assign w_s = r_st[w_gnt_id];
  assign w_c = r_cnt[w_gnt_id];
  assign w_x = q[w_gnt_id];

  always_comb begin
    w_nst  = w_s;
    w_ncnt = w_c;
    w_nz   = 1'b0;
    case (w_s)
      ST_A: begin
        if (w_x) begin
          w_nst  = ST_C;
          w_ncnt = '0;
        end else begin
          w_nst = ST_FG;
        end
      end
      ST_EH: w_nst = w_x ? ST_FG : ST_A;
      ST_BD: w_nst = w_x ? ST_FG : ST_EH;
      ST_FG: w_nst = ST_BD;
      ST_C: begin
        if (w_x) begin
          w_ncnt = '0;
        end else if (w_c < HOLD_C) begin
          w_ncnt = w_c + 5'd1;
          w_nz   = 1'b1;
        end else begin
          w_nst  = ST_EH;
          w_ncnt = HOLD_C;
          w_nz   = 1'b1;
        end
      end
      default: begin
        w_nst  = ST_A;
        w_ncnt = '0;
      end
    endcase
  end

  // Write-back lands at the same edge as the result, so a back-to-back grant reads fresh context.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (init || w_clr_mask[i]) begin
        r_st[i]  <= ST_A;
        r_cnt[i] <= '0;
      end else if (w_gnt_vld && (w_gnt_id == CHW'(i))) begin
        r_st[i]  <= w_nst;
        r_cnt[i] <= w_ncnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      r_ptr     <= PTR_RST;
      r_z_valid <= 1'b0;
      r_z       <= 1'b0;
      r_z_ch    <= '0;
      r_z_state <= '0;
      r_z_count <= '0;
    end else begin
      r_z_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_ptr     <= w_gnt_id;
        r_z       <= w_nz;
        r_z_ch    <= w_gnt_id;
        r_z_state <= w_nst;
        r_z_count <= w_ncnt;
      end
    end
  end

  assign z_valid = r_z_valid;
  assign z       = r_z;
  assign z_ch    = r_z_ch;
  assign z_state = r_z_state;
  assign z_count = r_z_count;

endmodule

// File: tb/tb_fsm_ctx_sched.sv
// Directed table-driven bench for fsm_ctx_sched; one vector per clock cycle.
module tb_fsm_ctx_sched;

  localparam logic [2:0] A = 3'd0, C = 3'd1, EH = 3'd2, BD = 3'd3, FG = 3'd4;

  logic       clk = 1'b0;
  logic       init, en, clr_ch;
  logic [3:0] req, q, ack;
  logic [1:0] clr_id, z_ch;
  logic       z_valid, z;
  logic [2:0] z_state;
  logic [4:0] z_count;

  int n_tests = 0;
  int n_fail  = 0;

  fsm_ctx_sched #(.NCH(4), .CHW(2), .HOLD_MAX(18)) dut (
    .clk(clk), .init(init), .en(en), .req(req), .q(q), .ack(ack),
    .clr_ch(clr_ch), .clr_id(clr_id), .z_valid(z_valid), .z(z),
    .z_ch(z_ch), .z_state(z_state), .z_count(z_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       init;
    logic       en;
    logic [3:0] req;
    logic [3:0] q;
    logic       clr_ch;
    logic [1:0] clr_id;
    logic       chk_ack;
    logic [3:0] exp_ack;
    logic       exp_zv;
    logic       chk_z;
    logic       exp_z;
    logic [1:0] exp_zch;
    logic [2:0] exp_st;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_rst(input logic [3:0] r);
    vec_t v;
    v = '{init: 1'b1, en: 1'b1, req: r, q: 4'b0, clr_ch: 1'b0, clr_id: 2'd0,
          chk_ack: 1'b0, exp_ack: 4'b0, exp_zv: 1'b0, chk_z: 1'b1,
          exp_z: 1'b0, exp_zch: 2'd0, exp_st: 3'd0, exp_cnt: 5'd0};
    vecs.push_back(v);
  endfunction

  function automatic void add_gnt(input logic [3:0] r, input logic [3:0] qq, input logic [3:0] a,
                                  input logic ez, input logic [1:0] ch, input logic [2:0] st,
                                  input logic [4:0] cnt, input logic cc = 1'b0,
                                  input logic [1:0] cid = 2'd0);
    vec_t v;
    v = '{init: 1'b0, en: 1'b1, req: r, q: qq, clr_ch: cc, clr_id: cid,
          chk_ack: 1'b1, exp_ack: a, exp_zv: 1'b1, chk_z: 1'b1,
          exp_z: ez, exp_zch: ch, exp_st: st, exp_cnt: cnt};
    vecs.push_back(v);
  endfunction

  function automatic void add_idle(input logic e, input logic [3:0] r, input logic cc,
                                   input logic [1:0] cid);
    vec_t v;
    v = '{init: 1'b0, en: e, req: r, q: 4'b0, clr_ch: cc, clr_id: cid,
          chk_ack: 1'b1, exp_ack: 4'b0, exp_zv: 1'b0, chk_z: 1'b0,
          exp_z: 1'b0, exp_zch: 2'd0, exp_st: 3'd0, exp_cnt: 5'd0};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    init = v.init; en = v.en; req = v.req; q = v.q; clr_ch = v.clr_ch; clr_id = v.clr_id;
    #1;
    if (v.chk_ack) check($sformatf("v%0d ack", idx), 32'(ack), 32'(v.exp_ack));
    @(posedge clk);
    #1;
    check($sformatf("v%0d z_valid", idx), 32'(z_valid), 32'(v.exp_zv));
    if (v.chk_z) begin
      check($sformatf("v%0d z", idx), 32'(z), 32'(v.exp_z));
      check($sformatf("v%0d z_ch", idx), 32'(z_ch), 32'(v.exp_zch));
      check($sformatf("v%0d z_state", idx), 32'(z_state), 32'(v.exp_st));
      check($sformatf("v%0d z_count", idx), 32'(z_count), 32'(v.exp_cnt));
    end
    $display("[TB] v%0d init=%0b en=%0b req=%b q=%b clr=%0b/%0d ack=%b zv=%0b z=%0b ch=%0d st=%0d cnt=%0d",
             idx, v.init, v.en, v.req, v.q, v.clr_ch, v.clr_id, ack, z_valid, z, z_ch, z_state, z_count);
  endtask

  initial begin
    vec_t v;
    init = 1'b1; en = 1'b0; req = '0; q = '0; clr_ch = 1'b0; clr_id = '0;

    // 1: ch0 alone, q=0,0,1,1 from A
    add_rst(4'b0000);
    add_gnt(4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, FG, 5'd0);
    add_gnt(4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, BD, 5'd0);
    add_gnt(4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, FG, 5'd0);
    add_gnt(4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, BD, 5'd0);
    // 2: ch1 hold counter up to HOLD_MAX then EH
    add_gnt(4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd1, C, 5'd0);
    for (int k = 1; k <= 18; k++)
      add_gnt(4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, C, 5'(k));
    add_gnt(4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, EH, 5'd18);
    // 3: all requesting, round robin, independent contexts
    add_rst(4'b0000);
    add_gnt(4'b1111, 4'b0100, 4'b0001, 1'b0, 2'd0, FG, 5'd0);
    add_gnt(4'b1111, 4'b0100, 4'b0010, 1'b0, 2'd1, FG, 5'd0);
    add_gnt(4'b1111, 4'b0100, 4'b0100, 1'b0, 2'd2, C,  5'd0);
    add_gnt(4'b1111, 4'b0100, 4'b1000, 1'b0, 2'd3, FG, 5'd0);
    add_gnt(4'b1111, 4'b0100, 4'b0001, 1'b0, 2'd0, BD, 5'd0);
    add_gnt(4'b1111, 4'b0100, 4'b0010, 1'b0, 2'd1, BD, 5'd0);
    add_gnt(4'b1111, 4'b0100, 4'b0100, 1'b0, 2'd2, C,  5'd0);
    add_gnt(4'b1111, 4'b0100, 4'b1000, 1'b0, 2'd3, BD, 5'd0);
    // 4: clear beats a simultaneous request
    add_rst(4'b0000);
    add_gnt(4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd3, C, 5'd0);
    for (int k = 1; k <= 5; k++)
      add_gnt(4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, C, 5'(k));
    add_idle(1'b1, 4'b1000, 1'b1, 2'd3);
    add_gnt(4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd3, FG, 5'd0);
    add_gnt(4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd3, BD, 5'd0, 1'b1, 2'd1);
    // 5: reset mid-stream, then enable gating
    add_gnt(4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, C, 5'd0);
    add_rst(4'b0011);
    add_gnt(4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0, FG, 5'd0);
    add_idle(1'b0, 4'b1111, 1'b0, 2'd0);
    add_idle(1'b0, 4'b1111, 1'b0, 2'd0);
    add_gnt(4'b1111, 4'b0000, 4'b0010, 1'b0, 2'd1, FG, 5'd0);

    foreach (vecs[i]) apply(i, vecs[i]);

    // Clear still acts while en=0: ch2 taken to C, cleared with en low, then steps from A.
    add_rst(4'b0000);
    apply(900, vecs[0]);
    v = '{init: 1'b0, en: 1'b1, req: 4'b0100, q: 4'b0100, clr_ch: 1'b0, clr_id: 2'd0,
          chk_ack: 1'b1, exp_ack: 4'b0100, exp_zv: 1'b1, chk_z: 1'b1,
          exp_z: 1'b0, exp_zch: 2'd2, exp_st: C, exp_cnt: 5'd0};
    apply(901, v);
    v.q = 4'b0000; v.exp_z = 1'b1; v.exp_cnt = 5'd1;
    apply(902, v);
    v = '{init: 1'b0, en: 1'b0, req: 4'b0100, q: 4'b0000, clr_ch: 1'b1, clr_id: 2'd2,
          chk_ack: 1'b1, exp_ack: 4'b0000, exp_zv: 1'b0, chk_z: 1'b0,
          exp_z: 1'b0, exp_zch: 2'd0, exp_st: 3'd0, exp_cnt: 5'd0};
    apply(903, v);
    v = '{init: 1'b0, en: 1'b1, req: 4'b0100, q: 4'b0000, clr_ch: 1'b0, clr_id: 2'd0,
          chk_ack: 1'b1, exp_ack: 4'b0100, exp_zv: 1'b1, chk_z: 1'b1,
          exp_z: 1'b0, exp_zch: 2'd2, exp_st: FG, exp_cnt: 5'd0};
    apply(904, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
